dma_write_sequencer: RTL and testbench

DMA_WRITE_SEQUENCER -- requirements
Module: dma_write_sequencer

---
 rtl/dma_write_sequencer.sv | 99 +++++++++
 tb/tb_dma_write_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_write_sequencer.sv
// dma_write_sequencer: turns a host-programmed job into back-to-back memory-write TLPs,
// then raises an MSI and holds busy until the core acknowledges it.
module dma_write_sequencer #(
   parameter int PAYLOAD_QW = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic [15:0] reqId_in,
   input  logic        regWrValid_in,
   input  logic        regWrSel_in,
   input  logic [31:0] regWrData_in,
   input  logic [63:0] srcData_in,
   input  logic        srcValid_in,
   output logic        srcReady_out,
   output logic [63:0] txData_out,
   output logic        txValid_out,
   output logic        txSop_out,
   output logic        txEop_out,
   input  logic        txReady_in,
   output logic        msiReq_out,
   input  logic        msiAck_in,
   output logic        busy_out
);
   localparam int BW = $clog2(PAYLOAD_QW + 1);
   typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, MSI} state_t;
   state_t state, state_nxt;
   logic [31:0] dmabase, addr;
   logic [CNT_WIDTH-1:0] cnt;
   logic [BW-1:0] beat;
   logic xfer, last, wr_base, wr_start;
   assign xfer     = txValid_out & txReady_in;
   assign last     = beat == BW'(PAYLOAD_QW - 1);
   assign wr_base  = state == IDLE && regWrValid_in && !regWrSel_in;
   assign wr_start = state == IDLE && regWrValid_in && regWrSel_in && |regWrData_in[CNT_WIDTH-1:0];
   always_ff @(posedge clk_in or posedge reset_in)
      if (reset_in) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = wr_start ? HDR0 : IDLE;
         HDR0: state_nxt = xfer ? HDR1 : HDR0;
         HDR1: state_nxt = xfer ? DATA : HDR1;
         DATA: state_nxt = (xfer && last) ? (cnt == CNT_WIDTH'(1) ? MSI : HDR0) : DATA;
         MSI:  state_nxt = msiAck_in ? IDLE : MSI;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk_in or posedge reset_in)
      if (reset_in) begin
         dmabase <= '0;
         addr    <= '0;
         cnt     <= '0;
         beat    <= '0;
      end else begin
         if (wr_base) dmabase <= {regWrData_in[31:3], 3'b000};
         if (wr_start) begin
            cnt  <= regWrData_in[CNT_WIDTH-1:0];
            addr <= dmabase;
            beat <= '0;
         end
         if (state == DATA && xfer) begin
            beat <= last ? '0 : beat + 1'b1;
            if (last) begin
               addr <= addr + 32'(PAYLOAD_QW * 8);
               cnt  <= cnt - 1'b1;
            end
         end
      end
   always_comb begin
      txValid_out  = 1'b0;
      txSop_out    = 1'b0;
      txEop_out    = 1'b0;
      txData_out   = '0;
      srcReady_out = 1'b0;
      msiReq_out   = 1'b0;
      case (state)
         HDR0: begin
            txValid_out = 1'b1;
            txSop_out   = 1'b1;
            txData_out  = {reqId_in, 8'h00, 8'hFF, 32'h4000_0000 | 32'(PAYLOAD_QW * 2)};
         end
         HDR1: begin
            txValid_out = 1'b1;
            txData_out  = {32'h0000_0000, addr};
         end
         DATA: begin
            txValid_out  = srcValid_in;
            txData_out   = srcData_in;
            srcReady_out = txReady_in;
            txEop_out    = last;
         end
         MSI: msiReq_out = 1'b1;
         default: ;
      endcase
   end
   assign busy_out = state != IDLE;
endmodule

// File: tb/tb_dma_write_sequencer.sv
// tb_dma_write_sequencer: directed scenarios for the DMA write sequencer; inputs change
// 1ns after the rising edge and transfers are logged on the falling edge.
module tb_dma_write_sequencer;
   localparam int QW = 16;
   localparam int TB = QW + 2;
   localparam logic [15:0] REQID = 16'hBEEF;
   logic clk = 1'b0, reset_in = 1'b1;
   logic [15:0] reqId_in = REQID;
   logic regWrValid_in = 1'b0, regWrSel_in = 1'b0;
   logic [31:0] regWrData_in = '0;
   logic [63:0] srcData_in = '0;
   logic srcValid_in = 1'b0, srcReady_out;
   logic [63:0] txData_out;
   logic txValid_out, txSop_out, txEop_out, txReady_in = 1'b1;
   logic msiReq_out, msiAck_in = 1'b0, busy_out;
   int checks = 0, errors = 0;
   logic [63:0] beats[$];
   bit sops[$], eops[$];
   int bcyc[$];
   int cyc = 0, msi_cnt = 0;

   dma_write_sequencer #(.PAYLOAD_QW(QW), .CNT_WIDTH(16)) dut (
      .clk_in(clk), .reset_in(reset_in), .reqId_in(reqId_in),
      .regWrValid_in(regWrValid_in), .regWrSel_in(regWrSel_in), .regWrData_in(regWrData_in),
      .srcData_in(srcData_in), .srcValid_in(srcValid_in), .srcReady_out(srcReady_out),
      .txData_out(txData_out), .txValid_out(txValid_out), .txSop_out(txSop_out),
      .txEop_out(txEop_out), .txReady_in(txReady_in),
      .msiReq_out(msiReq_out), .msiAck_in(msiAck_in), .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc++;
      if (!reset_in && txValid_out && txReady_in) begin
         beats.push_back(txData_out);
         sops.push_back(txSop_out);
         eops.push_back(txEop_out);
         bcyc.push_back(cyc);
      end
      if (!reset_in && msiReq_out && msiAck_in) msi_cnt++;
   end

   function automatic logic [63:0] pat(input int j);
      return {16'hCAFE, 16'(j), 32'(j * 3 + 1)};
   endfunction

   function automatic logic [65:0] exp_beat(input logic [31:0] base, input int i);
      int t = i / TB, k = i % TB;
      logic [63:0] d;
      if (k == 0) d = {REQID, 8'h00, 8'hFF, 32'h4000_0020};
      else if (k == 1) d = {32'h0, base + 32'(t * QW * 8)};
      else d = pat(t * QW + k - 2);
      return {d, k == 0, k == TB - 1};
   endfunction

   task automatic clear_mon();
      beats.delete(); sops.delete(); eops.delete(); bcyc.delete();
      msi_cnt = 0;
   endtask

   task automatic reg_wr(input logic sel, input logic [31:0] d);
      @(posedge clk); #1;
      regWrValid_in = 1'b1; regWrSel_in = sel; regWrData_in = d;
      @(posedge clk); #1;
      regWrValid_in = 1'b0;
   endtask

   task automatic run_job(input int n, input bit thr, input int stop, output bit done);
      int idx = 0;
      bit ack_pend = 0;
      done = 0;
      for (int c = 0; c < 5000; c++) begin
         @(posedge clk);
         if (stop != 0 && beats.size() == stop) return;
         #1;
         txReady_in  = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         srcValid_in = thr ? 1'($urandom_range(0, 1)) : 1'b1;
         srcData_in  = pat(idx);
         msiAck_in   = ack_pend;
         ack_pend    = 0;
         #3;
         if (srcValid_in && srcReady_out) idx++;
         if (msiAck_in) begin
            done = 1;
            break;
         end
         if (msiReq_out) begin
            ack_pend = 1;
            checks++;
            if (beats.size() != n * TB) begin
               errors++;
               $display("FAIL msi_timing: %0d beats before MSI, required %0d", beats.size(), n * TB);
            end
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL job_timeout: job of %0d TLPs never reached MSI ack", n);
         return;
      end
      @(posedge clk); #1;
      msiAck_in = 1'b0; srcValid_in = 1'b0; txReady_in = 1'b1;
      #3;
      if ({busy_out, msiReq_out} !== 2'b00) begin
         errors++;
         $display("FAIL busy_after_ack: busy=%b msi=%b, required 0 0", busy_out, msiReq_out);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({txValid_out, txSop_out, txEop_out, srcReady_out, msiReq_out, busy_out, txData_out} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: v%b s%b e%b r%b m%b b%b d%h, required all 0",
                  txValid_out, txSop_out, txEop_out, srcReady_out, msiReq_out, busy_out, txData_out);
      end
      reset_in = 1'b0;
   endtask

   task automatic test_single();
      bit d;
      clear_mon();
      reg_wr(1'b0, 32'h0000_0027);
      reg_wr(1'b1, 32'd1);
      run_job(1, 1'b0, 0, d);
      checks++;
      if (beats.size() != TB) begin errors++; $display("FAIL single_count: %0d beats, required %0d", beats.size(), TB); end
      for (int i = 0; i < beats.size() && i < TB; i++) begin
         checks++;
         if ({beats[i], sops[i], eops[i]} !== exp_beat(32'h20, i)) begin
            errors++;
            $display("FAIL single_beat%0d: %h/%b%b, required %h", i, beats[i], sops[i], eops[i], exp_beat(32'h20, i));
         end
      end
      checks++;
      if (msi_cnt != 1) begin errors++; $display("FAIL single_msi: %0d MSIs, required 1", msi_cnt); end
   endtask

   task automatic test_back_to_back();
      bit d;
      clear_mon();
      reg_wr(1'b1, 32'd3);
      run_job(3, 1'b0, 0, d);
      checks++;
      if (beats.size() != 3 * TB) begin errors++; $display("FAIL b2b_count: %0d beats, required %0d", beats.size(), 3 * TB); end
      for (int i = 0; i < beats.size() && i < 3 * TB; i++) begin
         checks++;
         if ({beats[i], sops[i], eops[i]} !== exp_beat(32'h20, i)) begin
            errors++;
            $display("FAIL b2b_beat%0d: %h/%b%b, required %h", i, beats[i], sops[i], eops[i], exp_beat(32'h20, i));
         end
      end
      checks++;
      if (beats.size() == 3 * TB && bcyc[3 * TB - 1] - bcyc[0] != 3 * TB - 1) begin
         errors++;
         $display("FAIL b2b_gapless: span %0d cycles, required %0d", bcyc[3 * TB - 1] - bcyc[0], 3 * TB - 1);
      end
      checks++;
      if (msi_cnt != 1) begin errors++; $display("FAIL b2b_msi: %0d MSIs, required 1", msi_cnt); end
   endtask

   task automatic test_throttle();
      bit d;
      int ns = 0, ne = 0;
      clear_mon();
      reg_wr(1'b0, 32'h0000_1000);
      reg_wr(1'b1, 32'd2);
      run_job(2, 1'b1, 0, d);
      checks++;
      if (beats.size() != 2 * TB) begin errors++; $display("FAIL thr_count: %0d beats, required %0d", beats.size(), 2 * TB); end
      for (int i = 0; i < beats.size() && i < 2 * TB; i++) begin
         ns += int'(sops[i]);
         ne += int'(eops[i]);
         checks++;
         if ({beats[i], sops[i], eops[i]} !== exp_beat(32'h1000, i)) begin
            errors++;
            $display("FAIL thr_beat%0d: %h/%b%b, required %h", i, beats[i], sops[i], eops[i], exp_beat(32'h1000, i));
         end
      end
      checks++;
      if (ns != 2 || ne != 2) begin errors++; $display("FAIL thr_sop_eop: sop %0d eop %0d, required 2 2", ns, ne); end
   endtask

   task automatic test_wrap();
      bit d;
      clear_mon();
      reg_wr(1'b0, 32'hFFFF_FF80);
      reg_wr(1'b1, 32'd2);
      run_job(2, 1'b0, 0, d);
      checks++;
      if (beats.size() != 2 * TB) begin
         errors++;
         $display("FAIL wrap_count: %0d beats, required %0d", beats.size(), 2 * TB);
      end else begin
         checks += 2;
         if (beats[1] !== 64'h0000_0000_FFFF_FF80) begin errors++; $display("FAIL wrap_addr0: %h, required ffffff80", beats[1]); end
         if (beats[TB + 1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1: %h, required 0", beats[TB + 1]); end
      end
   endtask

   task automatic test_ignore();
      bit d;
      clear_mon();
      reg_wr(1'b1, 32'd0);
      repeat (5) @(posedge clk);
      #3;
      checks++;
      if (beats.size() != 0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL zero_count: %0d beats busy=%b, required 0 beats busy=0", beats.size(), busy_out);
      end
      reg_wr(1'b0, 32'h0000_3000);
      reg_wr(1'b1, 32'd1);
      reg_wr(1'b0, 32'h0000_5000);
      reg_wr(1'b1, 32'd4);
      run_job(1, 1'b0, 0, d);
      checks++;
      if (beats.size() != TB || beats[1] !== 64'h3000) begin
         errors++;
         $display("FAIL busy_write: %0d beats, required %0d at addr 3000", beats.size(), TB);
      end
      clear_mon();
      reg_wr(1'b1, 32'd1);
      run_job(1, 1'b0, 0, d);
      checks++;
      if (beats.size() < 2 || beats[1] !== 64'h3000) begin
         errors++;
         $display("FAIL busy_base_kept: addr %h, required 3000", beats.size() < 2 ? 64'hx : beats[1]);
      end
   endtask

   task automatic test_reset_mid();
      bit d;
      clear_mon();
      reg_wr(1'b0, 32'h0000_0040);
      reg_wr(1'b1, 32'd1);
      run_job(1, 1'b0, 9, d);
      #2 reset_in = 1'b1;
      #1;
      checks++;
      if ({txValid_out, txSop_out, txEop_out, srcReady_out, msiReq_out, busy_out, txData_out} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: v%b s%b e%b r%b m%b b%b d%h, required all 0",
                  txValid_out, txSop_out, txEop_out, srcReady_out, msiReq_out, busy_out, txData_out);
      end
      @(posedge clk); #1;
      reset_in = 1'b0; srcValid_in = 1'b0; txReady_in = 1'b1;
      clear_mon();
      repeat (4) @(posedge clk);
      #3;
      checks++;
      if (beats.size() != 0 || busy_out !== 1'b0) begin
         errors++;
         $display("FAIL no_resume: %0d beats busy=%b, required 0 beats busy=0", beats.size(), busy_out);
      end
      reg_wr(1'b1, 32'd1);
      run_job(1, 1'b0, 0, d);
      checks++;
      if (beats.size() != TB) begin errors++; $display("FAIL post_reset_count: %0d beats, required %0d", beats.size(), TB); end
      for (int i = 0; i < beats.size() && i < TB; i++) begin
         checks++;
         if ({beats[i], sops[i], eops[i]} !== exp_beat(32'h0, i)) begin
            errors++;
            $display("FAIL post_reset_beat%0d: %h/%b%b, required %h", i, beats[i], sops[i], eops[i], exp_beat(32'h0, i));
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_throttle();
      test_wrap();
      test_ignore();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
